// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package reg_writeback_arbiter_pkg;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Two-entry FIFO of {rd, data} memory results; caller guarantees no push when full / pop when empty.
module wb_result_fifo
    import reg_writeback_arbiter_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [DATA_W-1:0] i_data,
    output logic [REG_AW-1:0] o_head_rd,
    output logic [DATA_W-1:0] o_head_data,
    output logic [1:0]        o_count
);
    wb_entry_t  r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= '{rd: i_rd, data: i_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_rd   = r_mem[r_rptr].rd;
    assign o_head_data = r_mem[r_rptr].data;
    assign o_count     = r_count;
endmodule

// File: rtl/reg_writeback_arbiter.sv
// ALU vs. queued-memory-result writeback arbiter with starvation back-pressure.
// Optional BYPASS_EN macro adds combinational forwarding of the in-flight write.
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_reg_write,
    output logic [REG_AW-1:0] o_write_reg,
    output logic [DATA_W-1:0] o_write_data,
    output logic [1:0]        o_q_count
`ifdef BYPASS_EN
    ,
    input  logic [REG_AW-1:0] i_byp_reg1,
    input  logic [REG_AW-1:0] i_byp_reg2,
    output logic              o_byp_hit1,
    output logic              o_byp_hit2,
    output logic [DATA_W-1:0] o_byp_data1,
    output logic [DATA_W-1:0] o_byp_data2
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0]     r_starve;
    logic [1:0]        w_count;
    logic [REG_AW-1:0] w_head_rd;
    logic [DATA_W-1:0] w_head_data;
    logic              w_q_busy;
    logic              w_alu_win;
    logic              w_pop;
    logic              w_push;

    // Ready signals derive only from registered state.
    assign w_q_busy    = (w_count != 2'd0);
    assign o_mem_ready = (w_count != 2'd2);
    assign o_alu_ready = !((r_starve == LIMIT) && w_q_busy);

    // An accepted ALU result to x0 is swallowed and leaves the slot to the queue.
    assign w_alu_win = i_alu_valid && o_alu_ready && (i_alu_rd != ZERO_REG);
    assign w_pop     = !w_alu_win && w_q_busy;
    assign w_push    = i_mem_valid && o_mem_ready && (i_mem_rd != ZERO_REG);

    wb_result_fifo u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_rd        (i_mem_rd),
        .i_data      (i_mem_data),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_count     (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_write  <= 1'b0;
            o_write_reg  <= ZERO_REG;
            o_write_data <= '0;
        end else if (w_alu_win) begin
            o_reg_write  <= 1'b1;
            o_write_reg  <= i_alu_rd;
            o_write_data <= i_alu_data;
        end else if (w_pop) begin
            o_reg_write  <= 1'b1;
            o_write_reg  <= w_head_rd;
            o_write_data <= w_head_data;
        end else begin
            o_reg_write  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_starve <= '0;
        else if (!w_q_busy || w_pop) r_starve <= '0;
        else if (r_starve != LIMIT)  r_starve <= r_starve + SW'(1);
    end

    assign o_q_count = w_count;

`ifdef BYPASS_EN
    assign o_byp_hit1  = o_reg_write && (o_write_reg == i_byp_reg1) && (i_byp_reg1 != ZERO_REG);
    assign o_byp_hit2  = o_reg_write && (o_write_reg == i_byp_reg2) && (i_byp_reg2 != ZERO_REG);
    assign o_byp_data1 = o_write_data;
    assign o_byp_data2 = o_write_data;
`endif
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_reg_writeback_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, write_reg;
    logic [31:0] alu_data, mem_data, write_data;
    logic        reg_write;
    logic [1:0]  q_count;
`ifdef BYPASS_EN
    logic [4:0]  byp_reg1, byp_reg2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
        .o_reg_write(reg_write), .o_write_reg(write_reg), .o_write_data(write_data), .o_q_count(q_count)
`ifdef BYPASS_EN
        , .i_byp_reg1(byp_reg1), .i_byp_reg2(byp_reg2), .o_byp_hit1(byp_hit1), .o_byp_hit2(byp_hit2),
        .o_byp_data1(byp_data1), .o_byp_data2(byp_data2)
`endif
    );

    // Reference model: queued results in acceptance order, starvation age, last write.
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } m_ent_t;
    m_ent_t      mq[$];
    int          m_starve;
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_rw = 0; m_wr = 0; m_wd = 0;
    endtask

    task automatic model_clock();
        bit ardy, mrdy, had, awin, pop;
        had  = (mq.size() != 0);
        ardy = !(m_starve == LIMIT && had);
        mrdy = (mq.size() != 2);
        awin = alu_valid && ardy && (alu_rd != 0);
        pop  = !awin && had;
        if (awin) begin
            m_rw = 1; m_wr = alu_rd; m_wd = alu_data;
        end else if (pop) begin
            m_rw = 1; m_wr = mq[0].rd; m_wd = mq[0].data;
            void'(mq.pop_front());
        end else begin
            m_rw = 0;
        end
        if (mem_valid && mrdy && mem_rd != 0) mq.push_back('{rd: mem_rd, data: mem_data});
        if (!had || pop)          m_starve = 0;
        else if (m_starve < LIMIT) m_starve = m_starve + 1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
`ifdef BYPASS_EN
        byp_reg1 = 0; byp_reg2 = 0;
`endif
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b exp=0", reg_write); end
        checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_wr got=%0d exp=0", write_reg); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wd got=%h exp=0", write_data); end
        checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL reset_qc got=%0d exp=0", q_count); end
        checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b%b exp=11", mem_ready, alu_ready); end
        @(posedge clk); #1 rst_n = 1;
        model_reset();
    endtask

    task automatic test_single_mem();
        apply_reset();
        mem_valid = 1; mem_rd = 5; mem_data = 32'hDEAD0001;
        @(posedge clk); #1 mem_valid = 0;
        checks++; if (q_count !== 2'd1 || reg_write !== 1'b0) begin errors++; $display("FAIL single_push got qc=%0d rw=%b exp qc=1 rw=0", q_count, reg_write); end
        @(posedge clk); #1;
        checks++; if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEAD0001)
            begin errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/dead0001", reg_write, write_reg, write_data); end
        checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL single_drain got=%0d exp=0", q_count); end
    endtask

    task automatic test_starvation();
        logic [4:0] exp_wr;
        apply_reset();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA0000003;
        mem_valid = 1; mem_rd = 7; mem_data = 32'h70;
        @(posedge clk); #1 mem_rd = 8; mem_data = 32'h80;
        checks++; if (reg_write !== 1'b1 || write_reg !== 5'd3 || q_count !== 2'd1)
            begin errors++; $display("FAIL starve_e1 got rw=%b wr=%0d qc=%0d exp 1/3/1", reg_write, write_reg, q_count); end
        @(posedge clk); #1 mem_valid = 0;
        checks++; if (q_count !== 2'd2 || mem_ready !== 1'b0 || alu_ready !== 1'b1)
            begin errors++; $display("FAIL starve_full got qc=%0d mr=%b ar=%b exp 2/0/1", q_count, mem_ready, alu_ready); end
        for (int e = 3; e <= 11; e++) begin
            @(posedge clk); #1;
            exp_wr = (e == 6) ? 5'd7 : (e == 11) ? 5'd8 : 5'd3;
            checks++; if (reg_write !== 1'b1 || write_reg !== exp_wr)
                begin errors++; $display("FAIL starve_wr edge=%0d got=%b/%0d exp=1/%0d", e, reg_write, write_reg, exp_wr); end
            checks++; if (alu_ready !== !(e == 5 || e == 10))
                begin errors++; $display("FAIL starve_ardy edge=%0d got=%b exp=%b", e, alu_ready, !(e == 5 || e == 10)); end
        end
        checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL starve_drain got=%0d exp=0", q_count); end
        alu_valid = 0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        mem_valid = 1; mem_rd = 10; mem_data = 32'h1010;
        @(posedge clk); #1 mem_rd = 11; mem_data = 32'h1111;
        @(posedge clk); #1 mem_valid = 0;
        checks++; if (q_count !== 2'd1 || write_reg !== 5'd10 || reg_write !== 1'b1)
            begin errors++; $display("FAIL same_cycle1 got qc=%0d wr=%0d exp qc=1 wr=10", q_count, write_reg); end
        @(posedge clk); #1;
        checks++; if (q_count !== 2'd0 || write_reg !== 5'd11 || write_data !== 32'h1111)
            begin errors++; $display("FAIL same_cycle2 got qc=%0d wr=%0d wd=%h exp 0/11/1111", q_count, write_reg, write_data); end
    endtask

    task automatic test_alu_zero();
        apply_reset();
        mem_valid = 1; mem_rd = 9; mem_data = 32'h9999;
        @(posedge clk); #1 mem_valid = 0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD0;
        @(posedge clk); #1;
        checks++; if (reg_write !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h9999)
            begin errors++; $display("FAIL alu_zero got=%b/%0d/%h exp=1/9/9999", reg_write, write_reg, write_data); end
        @(posedge clk); #1;
        checks++; if (reg_write !== 1'b0 || write_reg !== 5'd9 || write_data !== 32'h9999)
            begin errors++; $display("FAIL alu_zero_hold got=%b/%0d/%h exp=0/9/9999", reg_write, write_reg, write_data); end
        alu_valid = 0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        mem_valid = 1; mem_rd = 20; mem_data = 32'h20;
        @(posedge clk); #1 mem_rd = 21; mem_data = 32'h21;
        @(posedge clk); #1 mem_valid = 0;
        checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL midrst_fill got=%0d exp=2", q_count); end
        rst_n = 0; alu_valid = 0;
        #1;
        checks++; if (reg_write !== 1'b0 || q_count !== 2'd0)
            begin errors++; $display("FAIL midrst_now got rw=%b qc=%0d exp 0/0", reg_write, q_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++; if (reg_write !== 1'b0 || q_count !== 2'd0)
                begin errors++; $display("FAIL midrst_after cyc=%0d got rw=%b qc=%0d exp 0/0", c, reg_write, q_count); end
        end
    endtask

`ifdef BYPASS_EN
    task automatic test_bypass();
        apply_reset();
        alu_valid = 1; alu_rd = 12; alu_data = 32'h1234;
        byp_reg1 = 12; byp_reg2 = 0;
        @(posedge clk); #1 alu_valid = 0;
        checks++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h1234 || byp_hit2 !== 1'b0)
            begin errors++; $display("FAIL bypass got h1=%b d1=%h h2=%b exp 1/1234/0", byp_hit1, byp_data1, byp_hit2); end
        byp_reg2 = 12; byp_reg1 = 13;
        #1;
        checks++; if (byp_hit2 !== 1'b1 || byp_data2 !== 32'h1234 || byp_hit1 !== 1'b0)
            begin errors++; $display("FAIL bypass2 got h2=%b d2=%h h1=%b exp 1/1234/0", byp_hit2, byp_data2, byp_hit1); end
        @(posedge clk); #1;
        checks++; if (byp_hit2 !== 1'b0) begin errors++; $display("FAIL bypass_idle got=%b exp=0", byp_hit2); end
    endtask
`endif

    task automatic test_random();
        bit exp_ardy;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 2) != 0);
            mem_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            mem_data  = $urandom;
            @(negedge clk);
            exp_ardy = !(m_starve == LIMIT && mq.size() != 0);
            checks++; if (alu_ready !== exp_ardy)
                begin errors++; $display("FAIL rnd_ardy i=%0d got=%b exp=%b", i, alu_ready, exp_ardy); end
            checks++; if (mem_ready !== (mq.size() != 2) || q_count !== 2'(mq.size()))
                begin errors++; $display("FAIL rnd_q i=%0d got mr=%b qc=%0d exp qc=%0d", i, mem_ready, q_count, mq.size()); end
            model_clock();
            @(posedge clk); #1;
            checks++; if (reg_write !== m_rw || write_reg !== m_wr || write_data !== m_wd)
                begin errors++; $display("FAIL rnd_wb i=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, reg_write, write_reg, write_data, m_rw, m_wr, m_wd); end
            checks++; if (reg_write === 1'b1 && write_reg === 5'd0)
                begin errors++; $display("FAIL rnd_x0 i=%0d got write to register 0", i); end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_single_mem();
        test_starvation();
        test_same_cycle();
        test_alu_zero();
        test_reset_mid();
`ifdef BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
